map_window_scheduler: RTL and testbench
=======================================

Name: map_window_scheduler

Overview:
Sequences one frame of the MAP decoder using a sliding-window schedule. It drives the input symbol memory, the gamma unit, the alpha (forward) recursion and the beta (backward) recursion, including the dummy beta warm-up. Frame by frame, it first accepts a full frame of symbols into the input memory. It then runs alpha, dummy-beta and beta passes window by window and flags LLR outputs. It replaces ad-hoc fixed-count sequencing with a parameterised, restartable scheduler.

Parameters:
FRAME_LEN, 6144, symbols per frame; must be a multiple of WIN_LEN.
WIN_W, 5, log2 of window length; WIN_LEN = 2**WIN_W.
ADDR_W, 13, input-memory address width; 2**ADDR_W >= FRAME_LEN + WIN_LEN.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  begin frame; sampled only in IDLE.
abort  in  1  synchronous abort to IDLE; no done pulse.
in_valid  in  1  input symbol valid.
in_ready  out  1  scheduler accepts input symbol.
in_we  out  1  input-memory write enable = in_valid & in_ready.
in_addr  out  ADDR_W  input-memory write address.
rd_addr  out  ADDR_W  input-memory read address for gamma.
gamma_clr  out  1  clear gamma unit.
alpha_clr  out  1  initialise alpha metrics to the known start state.
alpha_en  out  1  alpha recursion step.
alpha_we  out  1  alpha-memory write.
alpha_addr  out  WIN_W  alpha-memory address.
beta_en  out  1  beta recursion step.
beta_init_unif  out  1  load uniform beta metrics.
beta_init_term  out  1  load terminated beta metrics.
mux_dummy  out  1  1 = beta path in dummy warm-up; LLR suppressed.
llr_valid  out  1  LLR output valid this cycle.
llr_addr  out  ADDR_W  symbol index of current LLR.
busy  out  1  not in IDLE.
done  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset (reset=0, async): state IDLE, all counters 0, every output 0.
- Output timing: all outputs except in_we are combinational decodes of registered state and counters; in_we is combinational from in_valid.
- Counters: window index w in 0..NW-1, where NW = FRAME_LEN/WIN_LEN. Step k in 0..WIN_LEN-1. Load counter n.
- IDLE: start=1 goes to LOAD with n=0. start in any other state is ignored.
- LOAD: in_ready=1 and in_addr=n. Each handshake increments n. The handshake with n=FRAME_LEN-1 moves to CLR.
- CLR (1 cycle): gamma_clr=1 and alpha_clr=1; w=0, k=0. Next state is ALPHA.
- ALPHA (WIN_LEN cycles):
  - Outputs: rd_addr = w*WIN_LEN+k, alpha_en=1, alpha_we=1, alpha_addr=k.
  - At k=WIN_LEN-1: go to BETA if w=NW-1, otherwise go to DUMMY; k resets to 0.
- DUMMY (WIN_LEN cycles):
  - Outputs: rd_addr = (w+2)*WIN_LEN-1-k (descending through window w+1), beta_en=1, mux_dummy=1.
  - beta_init_unif=1 on k=0 only.
  - Next state is BETA.
- BETA (WIN_LEN cycles):
  - Outputs: rd_addr = (w+1)*WIN_LEN-1-k, beta_en=1, mux_dummy=0, alpha_addr = WIN_LEN-1-k (read), llr_valid=1, llr_addr = rd_addr.
  - beta_init_term=1 on k=0 only when w=NW-1. For non-last windows, beta continues from the DUMMY result with no init pulse.
  - At k=WIN_LEN-1: go to DONE if w=NW-1, otherwise w+1 and go to ALPHA.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- abort=1 in any non-IDLE state: next state IDLE with counters cleared.
  - abort has priority over all transitions, including a LOAD handshake in the same cycle; in_ready stays 1 that cycle.
  - No done pulse is generated.
- Async reset mid-frame: immediate return to IDLE; outputs 0.
- Address arithmetic: unsigned, ADDR_W bits, never wraps for legal parameters. The DUMMY rd_addr is used only when w<NW-1, so its maximum is FRAME_LEN-1.
- Exclusivity:
  - alpha_we and llr_valid are never both 1.
  - beta_init_unif and beta_init_term are never both 1.
  - mux_dummy=1 implies llr_valid=0.
- Frame cycle count, from the cycle after the last load handshake: 1 + (NW-1)*3*WIN_LEN + 2*WIN_LEN, then the DONE cycle.

Test Plan:
- Reset: hold reset=0 with toggling start and in_valid -> all outputs 0, busy=0. Release reset -> still IDLE.
- Load with FRAME_LEN=64, WIN_W=3: start, then 64 in_valid beats with random gaps -> in_we exactly 64 times with in_addr 0..63 in order. in_ready drops the cycle after beat 63; gamma_clr=alpha_clr=1 for exactly that one cycle.
- Window schedule, same parameters:
  - Window 0 sequence: ALPHA rd_addr 0..7 with alpha_addr 0..7; then DUMMY rd_addr 15..8 with beta_init_unif on its first cycle; then BETA llr_addr 7..0 with alpha_addr 7..0.
  - Window 7: ALPHA 56..63, then BETA 63..56 with beta_init_term once, and no DUMMY phase.
- Completion, same parameters: done high in the 186th cycle after the last load handshake. Exactly 64 llr_valid cycles cover indices 0..63 once each; busy=0 on the following cycle.
- Abort: assert abort on a DUMMY cycle of window 3 -> IDLE next cycle, no done, no further llr_valid. A new start then runs a full clean frame.
- Async reset mid-BETA: drop reset between clock edges -> outputs 0 immediately. start ignored while busy: pulse start during ALPHA -> no effect on sequence or count.

Source files
------------

// File: rtl/map_window_scheduler.sv
// -----------------------------------------------------------------------------
// map_window_scheduler
//
// Sliding-window sequencer for one MAP decoder frame. It first fills the input
// symbol memory with a whole frame. It then walks the frame one window at a
// time: a forward alpha pass, a dummy backward warm-up over the following
// window, and the real backward beta pass. The beta pass emits the LLRs.
// The last window has no successor, so it skips the warm-up and starts beta
// from the terminated trellis state instead.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             begin a frame (only looked at while idle)
//   abort             synchronous return to idle, no done pulse
//   in_valid/in_ready input symbol handshake (transfer when both are 1)
//   in_we, in_addr    input-memory write port (in_we = in_valid & in_ready)
//   rd_addr           input-memory read address feeding the gamma unit
//   gamma_clr         clear the gamma unit
//   alpha_clr         load alpha metrics with the known start state
//   alpha_en/_we/_addr alpha recursion step and alpha-memory port
//   beta_en           beta recursion step
//   beta_init_unif    load uniform beta metrics (start of dummy warm-up)
//   beta_init_term    load terminated beta metrics (last window only)
//   mux_dummy         beta path is in dummy warm-up, so LLRs are not valid
//   llr_valid/llr_addr LLR strobe and its symbol index
//   busy, done        not idle / one-cycle frame-complete pulse
//   state_dbg         current FSM state: 0 idle, 1 load, 2 clr, 3 alpha,
//                     4 dummy, 5 beta, 6 done
//
// Handshake: a symbol transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_valid may be driven without looking at in_ready.
// in_ready is a pure decode of state and does not depend on in_valid.
// -----------------------------------------------------------------------------
module map_window_scheduler #(
    parameter int FRAME_LEN = 6144,
    parameter int WIN_W     = 5,
    parameter int ADDR_W    = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              in_we,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              gamma_clr,
    output logic              alpha_clr,
    output logic              alpha_en,
    output logic              alpha_we,
    output logic [WIN_W-1:0]  alpha_addr,
    output logic              beta_en,
    output logic              beta_init_unif,
    output logic              beta_init_term,
    output logic              mux_dummy,
    output logic              llr_valid,
    output logic [ADDR_W-1:0] llr_addr,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam int WIN_LEN = 2 ** WIN_W;
    localparam int NW      = FRAME_LEN / WIN_LEN;

    localparam logic [ADDR_W-1:0] LAST_N    = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_W    = ADDR_W'(NW - 1);
    localparam logic [WIN_W-1:0]  LAST_K    = WIN_W'(WIN_LEN - 1);
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
    localparam logic [WIN_W-1:0]  K_ONE     = WIN_W'(1);
    // Offsets from the start of window w to the top of window w+1 (dummy)
    // and to the top of window w (beta). Both passes walk downwards from there.
    localparam logic [ADDR_W-1:0] DUMMY_TOP = ADDR_W'(2 * WIN_LEN - 1);
    localparam logic [ADDR_W-1:0] BETA_TOP  = ADDR_W'(WIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLR   = 3'd2,
        S_ALPHA = 3'd3,
        S_DUMMY = 3'd4,
        S_BETA  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;   // load counter
    logic [ADDR_W-1:0] w_q, w_d;   // window index
    logic [WIN_W-1:0]  k_q, k_d;   // step within window

    logic              last_k;
    logic              last_w;
    logic [ADDR_W-1:0] win_base;
    logic [ADDR_W-1:0] k_ext;

    assign last_k   = (k_q == LAST_K);
    assign last_w   = (w_q == LAST_W);
    assign win_base = w_q << WIN_W;
    assign k_ext    = ADDR_W'(k_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            w_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            w_q     <= w_d;
            k_q     <= k_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        w_d     = w_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    n_d     = '0;
                end
            end
            S_LOAD: begin
                // in_ready is 1 throughout LOAD, so in_valid alone is a transfer.
                if (in_valid) begin
                    if (n_q == LAST_N) begin
                        state_d = S_CLR;
                        n_d     = '0;
                    end else begin
                        n_d = n_q + A_ONE;
                    end
                end
            end
            S_CLR: begin
                w_d     = '0;
                k_d     = '0;
                state_d = S_ALPHA;
            end
            S_ALPHA: begin
                k_d = k_q + K_ONE;
                if (last_k) begin
                    k_d     = '0;
                    state_d = last_w ? S_BETA : S_DUMMY;
                end
            end
            S_DUMMY: begin
                k_d = k_q + K_ONE;
                if (last_k) begin
                    k_d     = '0;
                    state_d = S_BETA;
                end
            end
            S_BETA: begin
                k_d = k_q + K_ONE;
                if (last_k) begin
                    k_d = '0;
                    if (last_w) begin
                        w_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        w_d     = w_q + A_ONE;
                        state_d = S_ALPHA;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over every transition, including a same-cycle load beat.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            n_d     = '0;
            w_d     = '0;
            k_d     = '0;
        end
    end

    // Output decode from registered state and counters only.
    always_comb begin
        in_ready       = 1'b0;
        in_addr        = '0;
        rd_addr        = '0;
        gamma_clr      = 1'b0;
        alpha_clr      = 1'b0;
        alpha_en       = 1'b0;
        alpha_we       = 1'b0;
        alpha_addr     = '0;
        beta_en        = 1'b0;
        beta_init_unif = 1'b0;
        beta_init_term = 1'b0;
        mux_dummy      = 1'b0;
        llr_valid      = 1'b0;
        llr_addr       = '0;
        done           = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                in_addr  = n_q;
            end
            S_CLR: begin
                gamma_clr = 1'b1;
                alpha_clr = 1'b1;
            end
            S_ALPHA: begin
                rd_addr    = win_base + k_ext;
                alpha_en   = 1'b1;
                alpha_we   = 1'b1;
                alpha_addr = k_q;
            end
            S_DUMMY: begin
                // Only reached for w < NW-1, so the top stays inside the frame.
                rd_addr        = win_base + DUMMY_TOP - k_ext;
                beta_en        = 1'b1;
                mux_dummy      = 1'b1;
                beta_init_unif = (k_q == '0);
            end
            S_BETA: begin
                rd_addr        = win_base + BETA_TOP - k_ext;
                beta_en        = 1'b1;
                alpha_addr     = LAST_K - k_q;
                llr_valid      = 1'b1;
                llr_addr       = win_base + BETA_TOP - k_ext;
                // Non-last windows carry on from the dummy warm-up metrics.
                beta_init_term = (k_q == '0) && last_w;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign in_we     = in_valid & in_ready;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_map_window_scheduler.sv
module tb_map_window_scheduler;

    localparam int FRAME_LEN = 64;
    localparam int WIN_W     = 3;
    localparam int ADDR_W    = 7;
    localparam int WIN_LEN   = 8;
    localparam int NW        = FRAME_LEN / WIN_LEN;
    localparam int DONE_CYC  = 1 + (NW - 1) * 3 * WIN_LEN + 2 * WIN_LEN + 1;
    localparam int W         = 13 + WIN_W + 2 * ADDR_W;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic              in_we;
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              gamma_clr;
    logic              alpha_clr;
    logic              alpha_en;
    logic              alpha_we;
    logic [WIN_W-1:0]  alpha_addr;
    logic              beta_en;
    logic              beta_init_unif;
    logic              beta_init_term;
    logic              mux_dummy;
    logic              llr_valid;
    logic [ADDR_W-1:0] llr_addr;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    map_window_scheduler #(
        .FRAME_LEN(FRAME_LEN),
        .WIN_W    (WIN_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_we         (in_we),
        .in_addr       (in_addr),
        .rd_addr       (rd_addr),
        .gamma_clr     (gamma_clr),
        .alpha_clr     (alpha_clr),
        .alpha_en      (alpha_en),
        .alpha_we      (alpha_we),
        .alpha_addr    (alpha_addr),
        .beta_en       (beta_en),
        .beta_init_unif(beta_init_unif),
        .beta_init_term(beta_init_term),
        .mux_dummy     (mux_dummy),
        .llr_valid     (llr_valid),
        .llr_addr      (llr_addr),
        .busy          (busy),
        .done          (done),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    // Addresses are only meaningful while their strobes are active, so they
    // are zeroed in the packed record otherwise.
    function automatic logic [W-1:0] mk(
        input logic bsy, input logic dn, input logic gc, input logic ac,
        input logic ae, input logic awe, input logic be, input logic bu,
        input logic bt, input logic md, input logic lv, input logic ir,
        input logic iw, input logic [WIN_W-1:0] aa,
        input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] la);
        logic [WIN_W-1:0]  aa_m;
        logic [ADDR_W-1:0] ra_m;
        logic [ADDR_W-1:0] la_m;
        aa_m = (awe | lv) ? aa : '0;
        ra_m = (ae | be) ? ra : '0;
        la_m = lv ? la : '0;
        return {bsy, dn, gc, ac, ae, awe, be, bu, bt, md, lv, ir, iw, aa_m, ra_m, la_m};
    endfunction

    function automatic logic [W-1:0] obs();
        return mk(busy, done, gamma_clr, alpha_clr, alpha_en, alpha_we, beta_en,
                  beta_init_unif, beta_init_term, mux_dummy, llr_valid, in_ready,
                  in_we, alpha_addr, rd_addr, llr_addr);
    endfunction

    function automatic logic [W-1:0] idle_rec();
        return mk(F, F, F, F, F, F, F, F, F, F, F, F, F, '0, '0, '0);
    endfunction

    function automatic logic [4*ADDR_W+WIN_W+15:0] all_outs();
        return {in_ready, in_we, in_addr, rd_addr, gamma_clr, alpha_clr, alpha_en,
                alpha_we, alpha_addr, beta_en, beta_init_unif, beta_init_term,
                mux_dummy, llr_valid, llr_addr, busy, done, state_dbg,
                ADDR_W'(0), 3'd0};
    endfunction

    // ---------------- reference model ----------------
    // Expected cycle-by-cycle schedule from the cycle after the last load
    // handshake: one clear cycle, then per window alpha up, dummy down through
    // the next window (not for the last window), beta down, then done, idle.
    task automatic build_frame();
        exp_q.delete();
        exp_q.push_back(mk(T, F, T, T, F, F, F, F, F, F, F, F, F, '0, '0, '0));
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < WIN_LEN; k++)
                exp_q.push_back(mk(T, F, F, F, T, T, F, F, F, F, F, F, F,
                                   WIN_W'(k), ADDR_W'(w * WIN_LEN + k), '0));
            if (w < NW - 1)
                for (int k = 0; k < WIN_LEN; k++)
                    exp_q.push_back(mk(T, F, F, F, F, F, T, (k == 0), F, T, F, F, F,
                                       '0, ADDR_W'((w + 2) * WIN_LEN - 1 - k), '0));
            for (int k = 0; k < WIN_LEN; k++) begin
                int idx;
                idx = (w + 1) * WIN_LEN - 1 - k;
                exp_q.push_back(mk(T, F, F, F, F, F, T, F, (k == 0 && w == NW - 1), F, T,
                                   F, F, WIN_W'(WIN_LEN - 1 - k), ADDR_W'(idx), ADDR_W'(idx)));
            end
        end
        exp_q.push_back(mk(T, T, F, F, F, F, F, F, F, F, F, F, F, '0, '0, '0));
        exp_q.push_back(idle_rec());
    endtask

    // ---------------- driver tasks ----------------
    // Returns at the negedge of the first cycle after the last beat.
    task automatic load_frame();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < FRAME_LEN; b++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                #1;
                n_checks++;
                if ({in_ready, in_we} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL load_gap beat=%0d got ready/we=%b%b want 10", b, in_ready, in_we);
                end
                @(negedge clk);
            end
            in_valid = 1'b1;
            #1;
            n_checks++;
            if ({in_ready, in_we, in_addr} !== {1'b1, 1'b1, ADDR_W'(b)}) begin
                n_fail++;
                $display("FAIL load_beat beat=%0d got ready=%b we=%b addr=%0d want 1 1 %0d",
                         b, in_ready, in_we, in_addr, b);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Walks the schedule against the model. abort_c/start_c/rst_c pick the
    // cycle (0 = clear cycle) to pulse abort, pulse start, or drop reset; -1 = never.
    task automatic check_run(input int abort_c, input int start_c, input int rst_c);
        int c;
        int done_c;
        int llr_cnt;
        bit seen[FRAME_LEN];
        bit cut;
        logic [W-1:0] e;
        logic [W-1:0] o;
        c = 0;
        done_c = -1;
        llr_cnt = 0;
        cut = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) seen[i] = 1'b0;
        build_frame();
        while (exp_q.size() != 0) begin
            if (c > 0) @(negedge clk);
            abort = (c == abort_c);
            start = (c == start_c);
            if (c == rst_c) begin
                #2;
                reset = 1'b0;
                #1;
                n_checks++;
                if (all_outs() !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset c=%0d got=%h want 0", c, all_outs());
                end
                @(negedge clk);
                reset = 1'b1;
                exp_q.delete();
                repeat (3) exp_q.push_back(idle_rec());
                cut = 1'b1;
                c++;
                continue;
            end
            #1;
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sched c=%0d got=%h want=%h", c, o, e);
            end
            n_checks++;
            if ((alpha_we && llr_valid) || (beta_init_unif && beta_init_term) ||
                (mux_dummy && llr_valid)) begin
                n_fail++;
                $display("FAIL exclusive c=%0d got we/lv/bu/bt/md=%b%b%b%b%b want no overlap",
                         c, alpha_we, llr_valid, beta_init_unif, beta_init_term, mux_dummy);
            end
            if (done === 1'b1) done_c = c + 1;
            if (llr_valid === 1'b1) begin
                llr_cnt++;
                if (llr_addr < FRAME_LEN) seen[llr_addr] = 1'b1;
            end
            if (c == abort_c) begin
                exp_q.delete();
                repeat (3) exp_q.push_back(idle_rec());
                cut = 1'b1;
            end
            c++;
        end
        abort = 1'b0;
        start = 1'b0;
        if (!cut) begin
            int missing;
            missing = 0;
            for (int i = 0; i < FRAME_LEN; i++) if (!seen[i]) missing++;
            n_checks++;
            if (done_c != DONE_CYC) begin
                n_fail++;
                $display("FAIL done_cycle got=%0d want=%0d", done_c, DONE_CYC);
            end
            n_checks++;
            if (llr_cnt != FRAME_LEN || missing != 0) begin
                n_fail++;
                $display("FAIL llr_cover got count=%0d missing=%0d want %0d 0", llr_cnt, missing, FRAME_LEN);
            end
        end else begin
            n_checks++;
            if (done_c != -1) begin
                n_fail++;
                $display("FAIL no_done got done at cycle %0d want none", done_c);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (all_outs() !== '0) begin
                n_fail++;
                $display("FAIL reset_hold i=%0d got=%h want 0", i, all_outs());
            end
        end
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (all_outs() !== '0) begin
                n_fail++;
                $display("FAIL reset_release got=%h want 0", all_outs());
            end
        end
    endtask

    task automatic test_frame();
        load_frame();
        check_run(-1, -1, -1);
    endtask

    task automatic test_start_ignored();
        load_frame();
        check_run(-1, 1 + 2 * 3 * WIN_LEN + int'($urandom_range(0, WIN_LEN - 1)), -1);
    endtask

    task automatic test_abort_dummy();
        load_frame();
        check_run(1 + 3 * 3 * WIN_LEN + WIN_LEN + int'($urandom_range(0, WIN_LEN - 1)), -1, -1);
        test_frame();
    endtask

    task automatic test_abort_load();
        int beats;
        beats = $urandom_range(3, 20);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        repeat (beats) @(negedge clk);
        abort = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, in_we, in_addr} !== {1'b1, 1'b1, ADDR_W'(beats)}) begin
            n_fail++;
            $display("FAIL abort_load got ready=%b we=%b addr=%0d want 1 1 %0d",
                     in_ready, in_we, in_addr, beats);
        end
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL abort_load_idle got=%h want 0", all_outs());
        end
    endtask

    task automatic test_async_reset();
        load_frame();
        check_run(-1, -1, 1 + 5 * 3 * WIN_LEN + 2 * WIN_LEN + int'($urandom_range(0, WIN_LEN - 1)));
    endtask

    task automatic test_back_to_back();
        test_frame();
        test_frame();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        test_reset();
        test_frame();
        test_start_ignored();
        test_abort_dummy();
        test_abort_load();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
